// File: rtl/priority_irq_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : priority_irq_encoder_pkg
//  Description : Shared sizes, FSM state type and reset constants for the
//                priority interrupt encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package priority_irq_encoder_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    // Presentation FSM: one-bit encoding, IDLE is the reset state.
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // Nothing pending out of reset; previous-sample register looks "all high"
    // so that only genuine falling edges are ever detected.
    localparam logic [NUM_REQ-1:0] c_PEND_RST   = '0;
    localparam logic [NUM_REQ-1:0] c_PREV_L_RST = '1;

endpackage
`default_nettype wire

// File: rtl/priority_irq_encoder_prio_enc8.sv
`default_nettype none
// ============================================================================
//  Module      : prio_enc8
//  Description : Combinational highest-set-bit selector over an 8-bit vector.
//                Bit 7 has the highest priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_enc8
    import priority_irq_encoder_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_vec,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    // Scan upward so the highest set bit overwrites any lower one.
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

    assign o_any = |i_vec;

endmodule
`default_nettype wire

// File: rtl/priority_irq_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : priority_irq_encoder
//  Description : Edge-detecting priority interrupt encoder. Falling edges on
//                the active-low request lines set pending bits; the highest
//                pending request is presented (VALID/A_L/GS_L) and held until
//                ACK, which retires it. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module priority_irq_encoder
    import priority_irq_encoder_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               EI_L,
    input  logic [NUM_REQ-1:0] I_L,
    input  logic               ACK,
    output logic [IDX_W-1:0]   A_L,
    output logic               VALID,
    output logic               GS_L,
    output logic               EO_L
);

    state_t               r_state;
    state_t               w_state_nxt;

    logic [NUM_REQ-1:0]   r_prev_l;
    logic [NUM_REQ-1:0]   r_block;
    logic [NUM_REQ-1:0]   r_pend;
    logic [IDX_W-1:0]     r_idx;

    logic [NUM_REQ-1:0]   w_det;
    logic [NUM_REQ-1:0]   w_clr;
    logic [NUM_REQ-1:0]   w_pend_nxt;
    logic [IDX_W-1:0]     w_enc_idx;
    logic                 w_enc_any;
    logic                 w_start;
    logic                 w_ack_done;
    logic [IDX_W-1:0]     w_idx_nxt;

    logic                 w_valid_nxt;
    logic                 w_gs_l_nxt;
    logic [IDX_W-1:0]     w_a_l_nxt;
    logic                 w_eo_l_nxt;

    prio_enc8 u_prio_enc8 (
        .i_vec (r_pend),
        .o_idx (w_enc_idx),
        .o_any (w_enc_any)
    );

    // r_block masks lines that were low when reset was applied, so a line
    // held low across reset is not seen as a fresh request until it has
    // gone high at least once.
    assign w_det      = r_prev_l & ~I_L & ~r_block;
    assign w_ack_done = (r_state == PRESENT) && ACK;
    assign w_clr      = w_ack_done ? (NUM_REQ'(1) << r_idx) : '0;
    // OR-ing detection after the clear makes a same-edge re-request win.
    assign w_pend_nxt = (r_pend & ~w_clr) | w_det;
    assign w_start    = (r_state == IDLE) && !EI_L && w_enc_any;
    assign w_idx_nxt  = w_start ? w_enc_idx : r_idx;

    // Request capture: previous-sample, reset block mask, pending set, index.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_prev_l <= c_PREV_L_RST;
            r_block  <= ~I_L;
            r_pend   <= c_PEND_RST;
            r_idx    <= '0;
        end else begin
            r_prev_l <= I_L;
            r_block  <= r_block & ~I_L;
            r_pend   <= w_pend_nxt;
            r_idx    <= w_idx_nxt;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: EI_L only gates the start of a presentation.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start)    w_state_nxt = PRESENT;
            PRESENT: if (w_ack_done) w_state_nxt = IDLE;
            default:                 w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs, computed one edge early so the ports come from flops.
    always_comb begin
        w_valid_nxt = (w_state_nxt == PRESENT);
        w_gs_l_nxt  = !w_valid_nxt;
        w_a_l_nxt   = w_valid_nxt ? ~w_idx_nxt : '1;
        w_eo_l_nxt  = !(!EI_L && (r_pend == '0) && (r_state == IDLE));
    end

    // Output registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            VALID <= 1'b0;
            GS_L  <= 1'b1;
            A_L   <= '1;
            EO_L  <= 1'b1;
        end else begin
            VALID <= w_valid_nxt;
            GS_L  <= w_gs_l_nxt;
            A_L   <= w_a_l_nxt;
            EO_L  <= w_eo_l_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_priority_irq_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_priority_irq_encoder
//  Description : Scoreboard bench for priority_irq_encoder. Stimulus pushes
//                the expected A_L of each presentation; a negedge monitor pops
//                and compares on every new VALID presentation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_irq_encoder;

    logic       clk;
    logic       rst;
    logic       ei_l;
    logic [7:0] i_l;
    logic       ack;
    logic [2:0] a_l;
    logic       valid;
    logic       gs_l;
    logic       eo_l;

    int         checks = 0;
    int         errors = 0;

    logic [2:0] exp_q[$];
    logic       mon_last = 1'b0;
    logic [2:0] mon_cur  = 3'b111;

    priority_irq_encoder dut (
        .CLK   (clk),
        .RESET (rst),
        .EI_L  (ei_l),
        .I_L   (i_l),
        .ACK   (ack),
        .A_L   (a_l),
        .VALID (valid),
        .GS_L  (gs_l),
        .EO_L  (eo_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        while (valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(name, {7'd0, valid}, 8'd1);
    endtask

    task automatic ack_once();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    // Monitor: pop on every new presentation, check A_L held while VALID.
    always @(negedge clk) begin
        if (valid === 1'b1 && !mon_last) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL present_unexpected: got A_L=%b expected no presentation", a_l);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                if (a_l !== e || gs_l !== 1'b0) begin
                    errors++;
                    $display("FAIL present: got A_L=%b GS_L=%b expected A_L=%b GS_L=0", a_l, gs_l, e);
                end
            end
            mon_cur = a_l;
        end else if (valid === 1'b1) begin
            checks++;
            if (a_l !== mon_cur || gs_l !== 1'b0) begin
                errors++;
                $display("FAIL hold: got A_L=%b GS_L=%b expected A_L=%b GS_L=0", a_l, gs_l, mon_cur);
            end
        end
        mon_last = (valid === 1'b1);
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst  = 1'b1;
        ei_l = 1'b0;
        i_l  = 8'hFF;
        ack  = 1'b0;

        // Reset then single request on bit 2.
        tick(2);
        chk("rst_valid", {7'd0, valid}, 8'd0);
        chk("rst_gs_l",  {7'd0, gs_l},  8'd1);
        chk("rst_a_l",   {5'd0, a_l},   8'd7);
        chk("rst_eo_l",  {7'd0, eo_l},  8'd1);
        rst = 1'b0;
        tick();
        chk("idle_eo_l", {7'd0, eo_l}, 8'd0);
        exp_q.push_back(3'b101);
        i_l = 8'hFB;
        tick();
        chk("lat_valid_k", {7'd0, valid}, 8'd0);
        tick();
        chk("lat_valid_k1", {7'd0, valid}, 8'd1);
        chk("lat_a_l",      {5'd0, a_l},   8'h05);
        chk("busy_eo_l",    {7'd0, eo_l},  8'd1);
        ack_once();
        chk("ack_valid", {7'd0, valid}, 8'd0);
        chk("ack_gs_l",  {7'd0, gs_l},  8'd1);
        chk("ack_a_l",   {5'd0, a_l},   8'd7);
        tick();
        chk("post_ack_eo_l", {7'd0, eo_l}, 8'd0);
        chk("held_no_rereq", {7'd0, valid}, 8'd0);
        i_l = 8'hFF;
        tick(2);

        // Simultaneous requests on bits 7, 4, 0.
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b111);
        i_l = 8'h6E;
        for (int r = 0; r < 3; r++) begin
            wait_valid("simul_valid", 10);
            tick();
            ack_once();
        end
        i_l = 8'hFF;
        tick(2);

        // No preemption: bit 1 presented, bit 6 arrives before ACK.
        exp_q.push_back(3'b110);
        exp_q.push_back(3'b001);
        i_l = 8'hFD;
        wait_valid("np_valid1", 10);
        i_l = 8'hBD;
        for (int r = 0; r < 3; r++) begin
            tick();
            chk("np_hold_a_l", {5'd0, a_l}, 8'h06);
        end
        ack_once();
        wait_valid("np_valid2", 10);
        ack_once();
        i_l = 8'hFF;
        tick(2);

        // EI_L gating with request on bit 3.
        ei_l = 1'b1;
        i_l  = 8'hF7;
        for (int r = 0; r < 4; r++) begin
            tick();
            chk("gate_valid", {7'd0, valid}, 8'd0);
            chk("gate_eo_l",  {7'd0, eo_l},  8'd1);
        end
        exp_q.push_back(3'b100);
        ei_l = 1'b0;
        tick();
        chk("ungate_valid", {7'd0, valid}, 8'd1);
        ack_once();
        i_l = 8'hFF;
        tick(2);

        // ACK / re-request collision on bit 5, then reset mid-presentation.
        exp_q.push_back(3'b010);
        exp_q.push_back(3'b010);
        i_l = 8'hDF;
        wait_valid("coll_valid1", 10);
        i_l = 8'hFF;
        tick();
        i_l = 8'hDF;
        ack_once();
        chk("coll_gap_valid", {7'd0, valid}, 8'd0);
        tick();
        chk("coll_valid2", {7'd0, valid}, 8'd1);
        chk("coll_a_l",    {5'd0, a_l},   8'h02);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_valid", {7'd0, valid}, 8'd0);
        chk("mrst_gs_l",  {7'd0, gs_l},  8'd1);
        chk("mrst_a_l",   {5'd0, a_l},   8'd7);
        chk("mrst_eo_l",  {7'd0, eo_l},  8'd1);
        for (int r = 0; r < 5; r++) begin
            tick();
            chk("mrst_no_repres", {7'd0, valid}, 8'd0);
        end
        // Line must rise and fall again to be seen.
        i_l = 8'hFF;
        tick();
        exp_q.push_back(3'b010);
        i_l = 8'hDF;
        wait_valid("refall_valid", 10);
        ack_once();
        i_l = 8'hFF;
        tick(3);

        chk("queue_empty", 8'(exp_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/priority_irq_encoder.md
PRIORITY_IRQ_ENCODER -- requirements
Module: priority_irq_encoder

Interface
REQ-001 SHALL have the following ports, in this order:
- CLK  in  1  single clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- EI_L  in  1  active-low enable for presentation.
- I_L  in  8  active-low request lines; bit 7 is the highest priority.
- ACK  in  1  consumer acknowledge.
- A_L  out  3  active-low encoded index of the presented request.
- VALID  out  1  presentation valid.
- GS_L  out  1  active-low group select.
- EO_L  out  1  active-low enable out.
REQ-002 SHALL use exactly one clock (CLK) and a synchronous, active-high reset (RESET); there are no other clocks or asynchronous inputs.

Function
REQ-003 SHALL register I_L each cycle into PREV_L; a request on bit n is detected when PREV_L[n]=1 and I_L[n]=0 at the same edge.
REQ-004 SHALL set PEND[n] on the edge at which request n is detected; a request line held low does not re-set PEND[n].
REQ-005 SHALL implement a two-state FSM with states IDLE and PRESENT.
REQ-006 IDLE -> PRESENT SHALL occur on the edge where EI_L=0 and PEND is nonzero.
- On that edge, IDX is latched as the highest set bit of PEND.
- Request detected at edge k -> VALID=1 after edge k+1, giving 2-cycle latency.
REQ-007 In PRESENT the block SHALL drive VALID=1, GS_L=0 and A_L=~IDX, holding A_L stable until ACK.
REQ-008 PRESENT with ACK=1 at an edge SHALL clear PEND[IDX] and return to IDLE; the next presentation occurs no earlier than the following edge.
REQ-009 ACK while in IDLE SHALL be ignored.
REQ-010 If a new request on bit IDX is detected on the same edge as its ACK, the set SHALL win and PEND[IDX] SHALL remain 1.
REQ-011 A higher-priority request arriving during PRESENT SHALL NOT preempt the current presentation; it is presented after ACK.
REQ-012 EI_L=1 SHALL block IDLE -> PRESENT only.
- Request capture continues while EI_L=1.
- A presentation already in progress completes normally.
REQ-013 EO_L SHALL be registered and equal 0 exactly when EI_L=0, PEND=0 and the state is IDLE, as sampled at the previous edge; otherwise EO_L=1.
REQ-014 In IDLE the block SHALL drive A_L=3'b111, GS_L=1 and VALID=0.

Reset
REQ-015 RESET=1 at an edge SHALL force the following values, regardless of state:
- State: IDLE.
- PEND=0, PREV_L=8'hFF, IDX=0.
- Outputs: VALID=0, GS_L=1, A_L=3'b111, EO_L=1.
REQ-016 Reset asserted mid-presentation SHALL discard the presentation and all pending requests; lines still held low after reset SHALL NOT be detected as new requests until they rise and fall again.

Structure
REQ-017 A shared package SHALL hold:
- NUM_REQ=8 and IDX_W=3.
- The FSM state type {IDLE, PRESENT}.
- The reset constants for PEND and PREV_L.
REQ-018 Highest-set-bit selection SHALL reside in one combinational sub-module, prio_enc8, with ports: 8-bit vector in, 3-bit index out, 1-bit any out.
REQ-019 All outputs SHALL be driven directly from registers.

Verification
REQ-020 Reset-then-single-request scenario:
- Stimulus: RESET for 2 cycles, EI_L=0, I_L=8'hFF, then I_L[2] falls.
- Required response: VALID=1 two edges later with A_L=3'b101 and GS_L=0; after ACK for 1 cycle, VALID=0 and EO_L=0 one cycle later.
REQ-021 Simultaneous-requests scenario:
- Stimulus: I_L goes 8'hFF -> 8'h6E (bits 7, 4, 0 fall together).
- Required response: A_L shows 000, 011 and 111 across three ACKs, i.e. indexes 7, 4, 0 in that order.
REQ-022 No-preemption scenario:
- Stimulus: bit 1 is being presented; bit 6 falls before ACK.
- Required response: A_L stays 3'b110 until ACK, then presents 3'b001.
REQ-023 EI_L-gating scenario:
- Stimulus: EI_L=1 while bit 3 falls.
- Required response: VALID stays 0 and EO_L=1; when EI_L drops to 0, VALID=1 with A_L=3'b100.
REQ-024 ACK/re-request-collision and mid-presentation-reset scenario:
- Stimulus: bit 5 is re-requested on the same edge as its ACK.
- Required response: bit 5 is presented again; RESET during PRESENT clears VALID next edge with no re-presentation while I_L is held.
